// File: rtl/switch_debounce_pkg.sv
// Shared defaults and width helper for the switch debouncer.
package switch_debounce_pkg;

  localparam int SW_WIDTH        = 18;
  localparam int SW_SYNC_STAGES  = 2;
  localparam int SW_TICK_DIV     = 50000;
  localparam int SW_STABLE_TICKS = 10;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/switch_debouncer_tick_gen.sv
// Sample-tick prescaler shared by every debounced bit; tick is high in the
// cycle the count equals TICK_DIV-1 (every cycle when TICK_DIV is 1).
module debounce_tick_gen
  import switch_debounce_pkg::*;
#(
  parameter int TICK_DIV = SW_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            PW   = cnt_width(TICK_DIV - 1);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count_q, count_d;

  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : count_q + PW'(1);
  end

  // NOTE: state updates use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the slide switches feeding the switches PIO.
// Optional edge-capture interrupt enabled by defining SWITCH_DEBOUNCE_IRQ_EN.
module switch_debouncer
  import switch_debounce_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int SYNC_STAGES  = SW_SYNC_STAGES,
  parameter int TICK_DIV     = SW_TICK_DIV,
  parameter int STABLE_TICKS = SW_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             change_strobe,
  output logic [WIDTH-1:0] changed_mask
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  ,
  output logic             irq,
  input  logic             irq_clear
`endif
);

  localparam int            CW       = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic             tick;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [CW-1:0]    cnt_d  [WIDTH];
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             strobe_q, strobe_d;

  debounce_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  always_comb begin
    sync_d[0] = sw_raw;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
  end

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latches.
    cnt_d    = cnt_q;
    stable_d = stable_q;
    mask_d   = '0;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync[i] == stable_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync[i];
          cnt_d[i]    = '0;
          mask_d[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    strobe_d = |mask_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '{default: '0};
      // NOTE: the counter array is reset on purpose so a reset discards any partial count.
      cnt_q    <= '{default: '0};
      stable_q <= '0;
      mask_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      mask_q   <= mask_d;
      strobe_q <= strobe_d;
    end
  end

  assign sw_stable     = stable_q;
  assign changed_mask  = mask_q;
  assign change_strobe = strobe_q;

`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic             irq_q, irq_d;

  // Captures the change on the same edge it is published, so irq follows the strobe by one cycle.
  always_comb begin
    edge_cap_d = (irq_clear ? '0 : edge_cap_q) | mask_d;
    irq_d      = |edge_cap_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      edge_cap_q <= edge_cap_d;
      irq_q      <= irq_d;
    end
  end

  assign irq = irq_q;
`endif

endmodule
